// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm time compare with edit keys, bounded ringing, snooze and stop
module alarm_ctrl #(
    parameter int ALARM_H_INIT = 7,
    parameter int ALARM_M_INIT = 0,
    parameter int RING_SEC     = 60,
    parameter int SNOOZE_SEC   = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       en,
    input  logic       set_mode,
    input  logic       key_hr,
    input  logic       key_min,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [1:0] state,
    output logic       ringing,
    output logic       buzz
);
    localparam int RW = RING_SEC > 1 ? $clog2(RING_SEC) : 1;
    localparam int SW = SNOOZE_SEC > 1 ? $clog2(SNOOZE_SEC) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
    state_t        r_state;
    logic [4:0]    r_alarm_h;
    logic [5:0]    r_alarm_m;
    logic          r_ringing;
    logic          r_buzz;
    logic          r_match_q;
    logic [3:0]    r_key_q;
    logic [RW-1:0] r_ring_cnt;
    logic [SW-1:0] r_snz_cnt;
    logic [3:0]    w_edge;
    logic          w_match;
    logic          w_trig;
    logic          w_ring_tick;
    logic          w_snz_tick;
    logic          w_to_idle;
    logic          w_to_ring;
    // w_edge bits: {stop, snooze, min, hr}
    assign w_edge      = {key_stop, key_snooze, key_min, key_hr} & ~r_key_q;
    assign w_match     = (hour == r_alarm_h) && (minute == r_alarm_m) && (second == 6'd0);
    assign w_trig      = w_match && !r_match_q;
    assign w_ring_tick = (r_state == RING) && tick_1hz;
    assign w_snz_tick  = (r_state == SNOOZE) && tick_1hz;
    // a snooze edge outranks the timeout tick, so the expiring tick only idles without it
    assign w_to_idle   = !en || set_mode || w_edge[3] ||
                         (w_ring_tick && !w_edge[2] && r_ring_cnt == RW'(RING_SEC - 1));
    assign w_to_ring   = ((r_state == IDLE) && w_trig) ||
                         (w_snz_tick && r_snz_cnt == SW'(SNOOZE_SEC - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_alarm_h  <= 5'(ALARM_H_INIT);
            r_alarm_m  <= 6'(ALARM_M_INIT);
            r_ringing  <= 1'b0;
            r_buzz     <= 1'b0;
            r_match_q  <= 1'b1;
            r_key_q    <= 4'hf;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
        end else begin
            r_key_q   <= {key_stop, key_snooze, key_min, key_hr};
            r_match_q <= w_match;
            if (set_mode && w_edge[0])
                r_alarm_h <= (r_alarm_h == 5'd23) ? 5'd0 : r_alarm_h + 5'd1;
            if (set_mode && w_edge[1])
                r_alarm_m <= (r_alarm_m == 6'd59) ? 6'd0 : r_alarm_m + 6'd1;
            if (w_to_idle) begin
                r_state    <= IDLE;
                r_ringing  <= 1'b0;
                r_buzz     <= 1'b0;
                r_ring_cnt <= '0;
                r_snz_cnt  <= '0;
            end else if (r_state == RING && w_edge[2]) begin
                r_state   <= SNOOZE;
                r_ringing <= 1'b0;
                r_buzz    <= 1'b0;
                r_snz_cnt <= '0;
            end else if (w_to_ring) begin
                r_state    <= RING;
                r_ringing  <= 1'b1;
                r_buzz     <= 1'b1;
                r_ring_cnt <= '0;
                r_snz_cnt  <= '0;
            end else if (w_ring_tick) begin
                r_ring_cnt <= r_ring_cnt + RW'(1);
                r_buzz     <= !r_buzz;
            end else if (w_snz_tick) begin
                r_snz_cnt <= r_snz_cnt + SW'(1);
            end
        end
    end
    assign alarm_hour = r_alarm_h;
    assign alarm_min  = r_alarm_m;
    assign state      = r_state;
    assign ringing    = r_ringing;
    assign buzz       = r_buzz;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed plus random stimulus checked against a seconds-level alarm model
module tb_alarm_ctrl;
    localparam int RING = 4;
    localparam int SNZ  = 6;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic       en = 1'b0;
    logic       set_mode = 1'b0;
    logic [3:0] kv = '0;
    logic       key_hr, key_min, key_stop, key_snooze;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [1:0] state;
    logic       ringing, buzz;
    int         n_vec = 0;
    int         n_err = 0;
    int         tsec = 0;
    int         m_ah, m_am, m_st, m_rs, m_sz;
    logic       m_pm;
    logic [3:0] m_pk;
    assign {key_stop, key_snooze, key_min, key_hr} = kv;
    alarm_ctrl #(.ALARM_H_INIT(7), .ALARM_M_INIT(0), .RING_SEC(RING), .SNOOZE_SEC(SNZ)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .hour(hour), .minute(minute), .second(second),
        .en(en), .set_mode(set_mode), .key_hr(key_hr), .key_min(key_min), .key_stop(key_stop),
        .key_snooze(key_snooze), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .state(state),
        .ringing(ringing), .buzz(buzz)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // model state: st 0/1/2, rs = ticks rung so far, sz = ticks snoozed so far
    task automatic model();
        logic [3:0] e;
        logic       m, trig;
        if (rst) begin
            m_ah = 7; m_am = 0; m_st = 0; m_rs = 0; m_sz = 0; m_pk = 4'hf; m_pm = 1'b1;
        end else begin
            e    = kv & ~m_pk;
            m    = (int'(hour) == m_ah) && (int'(minute) == m_am) && (second == 6'd0);
            trig = m && !m_pm;
            m_pk = kv;
            m_pm = m;
            if (set_mode && e[0]) m_ah = (m_ah + 1) % 24;
            if (set_mode && e[1]) m_am = (m_am + 1) % 60;
            if (!en || set_mode || e[3]) m_st = 0;
            else if (e[2] && m_st == 1) begin m_st = 2; m_sz = 0; end
            else if (m_st == 0) begin
                if (trig) begin m_st = 1; m_rs = 0; end
            end else if (m_st == 1) begin
                if (tick_1hz) begin
                    if (m_rs + 1 == RING) m_st = 0;
                    else m_rs++;
                end
            end else if (tick_1hz) begin
                if (m_sz + 1 == SNZ) begin m_st = 1; m_rs = 0; end
                else m_sz++;
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("alarm_hour", 32'(alarm_hour), m_ah);
        chk("alarm_min", 32'(alarm_min), m_am);
        chk("state", 32'(state), m_st);
        chk("ringing", 32'(ringing), 32'(m_st == 1));
        chk("buzz", 32'(buzz), 32'(m_st == 1 && m_rs % 2 == 0));
    endtask
    task automatic set_t(input int t);
        tsec   = t;
        hour   = 5'(t / 3600);
        minute = 6'((t / 60) % 60);
        second = 6'(t % 60);
    endtask
    task automatic tick(input bit adv);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        if (adv) set_t((tsec + 1) % 86400);
        step();
    endtask
    task automatic press(input int b);
        kv[b] = 1'b1;
        step();
        kv[b] = 1'b0;
        step();
    endtask
    task automatic retrig();
        second = 6'd1;
        step();
        second = 6'd0;
        step();
    endtask
    initial begin
        kv = 4'b0001;
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_hour", 32'(alarm_hour), 7);
        chk("rst_buzz", 32'(buzz), 0);
        rst = 1'b0;
        set_mode = 1'b1;
        step();
        kv = '0;
        step();
        chk("held_hr_thru_rst", 32'(alarm_hour), 7);
        repeat (17) press(0);
        chk("hour_wrap", 32'(alarm_hour), 0);
        repeat (61) press(1);
        chk("min_wrap", 32'(alarm_min), 1);
        kv[0] = 1'b1;
        repeat (100) step();
        kv[0] = 1'b0;
        step();
        chk("held_once", 32'(alarm_hour), 1);
        set_mode = 1'b0;
        press(0);
        press(1);
        chk("no_edit_hr", 32'(alarm_hour), 1);
        chk("no_edit_min", 32'(alarm_min), 1);
        set_mode = 1'b1;
        repeat (6) press(0);
        repeat (59) press(1);
        set_mode = 1'b0;
        chk("restore", 32'({alarm_hour, alarm_min}), 32'({5'd7, 6'd0}));
        en = 1'b1;
        set_t(6 * 3600 + 59 * 60 + 59);
        step();
        tick(1);
        chk("trig_ring", 32'(ringing), 1);
        chk("trig_buzz", 32'(buzz), 1);
        tick(0); chk("buzz_t1", 32'(buzz), 0);
        tick(0); chk("buzz_t2", 32'(buzz), 1);
        tick(0); chk("buzz_t3", 32'(buzz), 0);
        tick(0); chk("timeout", 32'(state), 0);
        repeat (5) step();
        chk("no_retrig", 32'(state), 0);
        retrig();
        chk("ring2", 32'(state), 1);
        press(2);
        chk("snooze", 32'(state), 2);
        chk("snooze_ringing", 32'(ringing), 0);
        repeat (5) tick(0);
        chk("snooze_hold", 32'(state), 2);
        tick(0);
        chk("rering", 32'(state), 1);
        chk("rering_buzz", 32'(buzz), 1);
        press(3);
        chk("stop", 32'(state), 0);
        retrig();
        kv = 4'b1100;
        step();
        chk("stop_and_snooze", 32'(state), 0);
        kv = '0;
        step();
        retrig();
        press(2);
        en = 1'b0;
        step();
        chk("en_off_snooze", 32'(state), 0);
        en = 1'b1;
        step();
        retrig();
        set_mode = 1'b1;
        step();
        chk("setmode_ring", 32'(state), 0);
        set_mode = 1'b0;
        step();
        retrig();
        repeat (3) tick(0);
        kv[3] = 1'b1;
        tick_1hz = 1'b1;
        step();
        kv[3] = 1'b0;
        tick_1hz = 1'b0;
        chk("stop_with_tick", 32'(state), 0);
        repeat (4) step();
        chk("no_false_rering", 32'(state), 0);
        set_mode = 1'b1;
        press(0);
        set_mode = 1'b0;
        set_t(8 * 3600);
        retrig();
        chk("ring_at_8", 32'(buzz), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_buzz", 32'(buzz), 0);
        chk("midrst_time", 32'({alarm_hour, alarm_min}), 32'({5'd7, 6'd0}));
        for (int i = 0; i < 4000; i++) begin
            if (tick_1hz) set_t((tsec + 1) % 86400);
            if (i % 150 == 0) set_t((m_ah * 3600 + m_am * 60 - int'($urandom_range(1, 3)) + 86400) % 86400);
            tick_1hz = !tick_1hz && ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 99) == 0) en = !en;
            if ($urandom_range(0, 79) == 0) set_mode = !set_mode;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 29) == 0) kv[b] = !kv[b];
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
